ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
//  Detects M-extension R-type instructions on the ID/EX outputs and latches their operands.
//  Stalls the front end through ctrl while it iterates, then presents one write-back result to the regs/WB path.
//  Non-M instructions are ignored; the plain ALU handles them in parallel.
// PARAMETERS
//  XLEN      32  operand/result width; only 32 is supported.
//  FAST_MUL  0   0: multiply iterates 32 cycles (shift-add). 1: multiply completes in 1 CALC cycle using '*'.
// PORTS
//  clk             in   1   core clock
//  rst             in   1   asynchronous, active-low reset
//  inst_i          in   32  instruction from id_ex
//  op1_i           in   32  rs1 value from id_ex
//  op2_i           in   32  rs2 value from id_ex
//  rd_addr_i       in   5   destination register from id_ex
//  reg_wen_i       in   1   write enable from id_ex; an M op is accepted only when this is 1
//  flush_i         in   1   ctrl cancel: abort the current operation, no write-back
//  hold_flag_o     out  1   stall request to ctrl (freezes pc/if_id/id_ex)
//  result_valid_o  out  1   one-cycle write-back strobe
//  rd_data_o       out  32  result
//  rd_addr_o       out  5   destination register of the result
//  reg_wen_o       out  1   register write enable (== result_valid_o)
// BEHAVIOUR
//  - Decode: is_m = (inst_i[6:0]==7'b0110011) && (inst_i[31:25]==7'b0000001).
//    funct3 selects the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
//  - Reset (rst==0, async): state=IDLE, counter=0, all outputs 0, operand registers 0.
//  - FSM states: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE:
//    - If is_m && reg_wen_i && !flush_i: latch funct3, rd_addr, |op1|, |op2|, result sign and raw op1.
//    - hold_flag_o is asserted combinationally in this same cycle T.
//    - Next state is CALC, or DONE for the special cases below.
//  - CALC: counter runs 0..31, one step per cycle. hold_flag_o=1 throughout. inst_i is ignored (id_ex supplies NOP while held).
//  - DONE: hold_flag_o=0; result_valid_o=reg_wen_o=1 for exactly 1 cycle; rd_data_o/rd_addr_o valid. Next state IDLE.
//    rd_data_o/rd_addr_o hold their value until the next DONE; reg_wen_o=0 outside DONE.
//  - Latency: issue in T, CALC in T+1..T+32, DONE in T+33. Hold is high for T..T+32 (33 cycles).
//    FAST_MUL=1 multiplies: DONE in T+2.
//  - Multiply: unsigned 64-bit product of the magnitudes, negated when the result sign is negative.
//    MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32]. MULHSU treats op2 as unsigned.
//  - Divide: restoring, 1 quotient bit per cycle on the magnitudes.
//    Quotient sign = s1^s2; remainder sign = s1 (signed ops only).
//  - Special cases skip CALC and go IDLE -> DONE (DONE in T+1):
//    - op2==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result op1.
//    - DIV op1==0x80000000 && op2==0xFFFFFFFF: result 0x80000000; REM result 0.
//  - flush_i:
//    - In CALC or DONE: next state IDLE, no write-back strobe; hold_flag_o drops the next cycle.
//    - In IDLE: blocks acceptance.
//  - Reset asserted mid-operation: immediate return to the reset values; the operation is lost.
//  - No back-to-back issue: the cycle after DONE is IDLE and may accept a new M op.
// STRUCTURE
//  - defines.v (shared): `INST_TYPE_R_M` opcode, `FUNCT7_M`, the eight funct3 codes, `INST_NOP`,
//    and 2-bit state encodings MD_IDLE/MD_CALC/MD_DONE.
//  - One sub-module: md_iter_core. Holds the 64-bit accumulator/remainder shift register and one
//    add/subtract step per cycle, controlled by a mul/div select; ex_muldiv owns the FSM, decode,
//    sign fix-up and special cases.
//  - Registers that need a reset value use the team dff/reset style with async active-low reset.
// TESTING
//  1. MUL op1=7, op2=0xFFFFFFFD (-3) issued at T -> hold high T..T+32; at T+33 reg_wen_o=1, rd_data_o=0xFFFFFFEB.
//  2. DIVU 100/7 -> 0x0000000E. REMU 100/7 -> 0x00000002. DIV -100/7 -> 0xFFFFFFF2. REM -100/7 -> 0xFFFFFFFE.
//  3. DIV 5/0 -> 0xFFFFFFFF at T+1. REMU 5/0 -> 0x00000005 at T+1. hold high only in T.
//  4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0x00000000. Both at T+1.
//  5. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  6. rst low at CALC cycle 10 -> all outputs 0 immediately, state IDLE.
//     flush_i at CALC cycle 5 -> no reg_wen_o pulse, hold_flag_o low next cycle.
//     A non-M ADD on inst_i -> hold_flag_o never asserts.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
//==============================================================================
// Module      : ex_muldiv_pkg
// Description : Shared RV32M decode constants and state encoding for ex_muldiv.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ex_muldiv_pkg;

    localparam logic [6:0]  c_INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0]  c_FUNCT7_M      = 7'b0000001;
    localparam logic [31:0] c_INST_NOP      = 32'h0000_0013;

    localparam logic [2:0]  c_F3_MUL    = 3'b000;
    localparam logic [2:0]  c_F3_MULH   = 3'b001;
    localparam logic [2:0]  c_F3_MULHSU = 3'b010;
    localparam logic [2:0]  c_F3_MULHU  = 3'b011;
    localparam logic [2:0]  c_F3_DIV    = 3'b100;
    localparam logic [2:0]  c_F3_DIVU   = 3'b101;
    localparam logic [2:0]  c_F3_REM    = 3'b110;
    localparam logic [2:0]  c_F3_REMU   = 3'b111;

    localparam logic [1:0]  c_MD_IDLE = 2'd0;
    localparam logic [1:0]  c_MD_CALC = 2'd1;
    localparam logic [1:0]  c_MD_DONE = 2'd2;

    typedef enum logic [1:0] {
        MD_IDLE = c_MD_IDLE,
        MD_CALC = c_MD_CALC,
        MD_DONE = c_MD_DONE
    } md_state_t;

    function automatic logic is_m_inst(input logic [6:0] funct7, input logic [6:0] opcode);
        return (opcode == c_INST_TYPE_R_M) && (funct7 == c_FUNCT7_M);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_if.sv
//==============================================================================
// Module      : ex_muldiv_if
// Description : ID/EX-side request and write-back bundle of the mul/div unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ex_muldiv_if;
    logic [31:0] inst_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wen_i;
    logic        flush_i;
    logic        hold_flag_o;
    logic        result_valid_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen_o;

    modport master (
        output inst_i, op1_i, op2_i, rd_addr_i, reg_wen_i, flush_i,
        input  hold_flag_o, result_valid_o, rd_data_o, rd_addr_o, reg_wen_o
    );

    modport slave (
        input  inst_i, op1_i, op2_i, rd_addr_i, reg_wen_i, flush_i,
        output hold_flag_o, result_valid_o, rd_data_o, rd_addr_o, reg_wen_o
    );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_md_iter_core.sv
//==============================================================================
// Module      : md_iter_core
// Description : 64-bit shift register doing one shift-add (mul) or one
//               restoring-subtract (div) step per cycle on unsigned operands.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module md_iter_core #(
    parameter int XLEN = 32
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_load,
    input  wire logic                i_step,
    input  wire logic                i_is_div,
    input  wire logic [XLEN-1:0]     i_lo,
    input  wire logic [XLEN-1:0]     i_opnd,
    output logic      [2*XLEN-1:0]   o_acc,
    output logic      [2*XLEN-1:0]   o_acc_next,
    output logic      [XLEN-1:0]     o_opnd
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_is_div;
    logic [XLEN:0]     w_sum;
    logic [XLEN+1:0]   w_trial;
    logic [2*XLEN-1:0] w_next;
    logic              w_unused;

    // Mul: conditionally add multiplicand to the high half, then shift right.
    assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    // Div: the shifted partial remainder can be XLEN+1 bits wide.
    assign w_trial = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_opnd};
    assign w_unused = w_trial[XLEN];

    always_comb begin
        w_next = {w_sum, r_acc[XLEN-1:1]};
        if (r_is_div) begin
            if (w_trial[XLEN+1]) begin
                w_next = {r_acc[2*XLEN-2:0], 1'b0};
            end else begin
                w_next = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {{XLEN{1'b0}}, i_lo};
            r_opnd   <= i_opnd;
            r_is_div <= i_is_div;
        end else if (i_step) begin
            r_acc    <= w_next;
        end
    end

    assign o_acc      = r_acc;
    assign o_acc_next = w_next;
    assign o_opnd     = r_opnd;

endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
//==============================================================================
// Module      : ex_muldiv
// Description : Iterative RV32M multiply/divide unit in EX; stalls the front end
//               while iterating and emits one write-back strobe per M op.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    ex_muldiv_if.slave   md
);

    md_state_t         r_state, w_state_next;
    logic [4:0]        r_cnt;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd_addr_p;
    logic              r_neg;
    logic [XLEN-1:0]   r_rd_data;
    logic [4:0]        r_rd_addr;

    logic [2:0]        w_f3;
    logic              w_is_m, w_s1, w_s2, w_neg;
    logic [XLEN-1:0]   w_mag1, w_mag2;
    logic              w_div0, w_ovf, w_special;
    logic [XLEN-1:0]   w_special_val;
    logic              w_accept, w_hold, w_valid, w_store, w_last;
    logic [2*XLEN-1:0] w_core_acc, w_core_acc_next, w_fast_prod, w_raw, w_prod_s;
    logic [XLEN-1:0]   w_core_opnd, w_quo_rem, w_result;
    logic              w_unused;

    assign w_f3   = md.inst_i[14:12];
    assign w_is_m = is_m_inst(md.inst_i[31:25], md.inst_i[6:0]);

    always_comb begin
        w_s1 = 1'b0;
        w_s2 = 1'b0;
        case (w_f3)
            c_F3_MUL, c_F3_MULH, c_F3_DIV, c_F3_REM: begin
                w_s1 = md.op1_i[XLEN-1];
                w_s2 = md.op2_i[XLEN-1];
            end
            c_F3_MULHSU:                    w_s1 = md.op1_i[XLEN-1];
            c_F3_MULHU, c_F3_DIVU, c_F3_REMU: ;
            default: ;
        endcase
    end

    assign w_mag1 = w_s1 ? -md.op1_i : md.op1_i;
    assign w_mag2 = w_s2 ? -md.op2_i : md.op2_i;
    // Remainder takes the dividend's sign; everything else takes s1^s2.
    assign w_neg  = (w_f3 == c_F3_REM) ? w_s1 : (w_s1 ^ w_s2);

    assign w_div0 = w_f3[2] && (md.op2_i == '0);
    assign w_ovf  = ((w_f3 == c_F3_DIV) || (w_f3 == c_F3_REM)) &&
                    (md.op1_i == 32'h8000_0000) && (md.op2_i == 32'hFFFF_FFFF);
    assign w_special = w_div0 || w_ovf;
    always_comb begin
        if (w_div0) w_special_val = w_f3[1] ? md.op1_i : '1;
        else        w_special_val = w_f3[1] ? '0 : 32'h8000_0000;
    end

    assign w_last = (r_cnt == 5'd31) || (FAST_MUL && !r_funct3[2]);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_hold       = 1'b0;
        w_valid      = 1'b0;
        w_store      = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (rst && w_is_m && md.reg_wen_i && !md.flush_i) begin
                    w_accept     = 1'b1;
                    w_hold       = 1'b1;
                    w_state_next = w_special ? MD_DONE : MD_CALC;
                end
            end
            MD_CALC: begin
                w_hold = 1'b1;
                if (md.flush_i) begin
                    w_state_next = MD_IDLE;
                end else if (w_last) begin
                    w_store      = 1'b1;
                    w_state_next = MD_DONE;
                end
            end
            MD_DONE: begin
                w_valid      = !md.flush_i;
                w_state_next = MD_IDLE;
            end
            default: w_state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= MD_IDLE;
        else      r_state <= w_state_next;
    end

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (r_state == MD_CALC),
        .i_is_div   (w_f3[2]),
        .i_lo       (w_f3[2] ? w_mag1 : w_mag2),
        .i_opnd     (w_f3[2] ? w_mag2 : w_mag1),
        .o_acc      (w_core_acc),
        .o_acc_next (w_core_acc_next),
        .o_opnd     (w_core_opnd)
    );

    if (FAST_MUL) begin : g_fast_mul
        assign w_fast_prod = {{XLEN{1'b0}}, w_core_opnd} * {{XLEN{1'b0}}, w_core_acc[XLEN-1:0]};
    end else begin : g_iter_mul
        assign w_fast_prod = '0;
    end

    assign w_raw     = (FAST_MUL && !r_funct3[2]) ? w_fast_prod : w_core_acc_next;
    assign w_prod_s  = r_neg ? -w_raw : w_raw;
    assign w_quo_rem = r_funct3[1] ? w_raw[2*XLEN-1:XLEN] : w_raw[XLEN-1:0];
    always_comb begin
        if (r_funct3[2])                w_result = r_neg ? -w_quo_rem : w_quo_rem;
        else if (r_funct3 == c_F3_MUL)  w_result = w_prod_s[XLEN-1:0];
        else                            w_result = w_prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_funct3    <= '0;
            r_rd_addr_p <= '0;
            r_neg       <= 1'b0;
            r_rd_data   <= '0;
            r_rd_addr   <= '0;
        end else begin
            if (w_accept) begin
                r_funct3    <= w_f3;
                r_rd_addr_p <= md.rd_addr_i;
                r_neg       <= w_neg;
            end
            if (w_accept && w_special) begin
                r_rd_data <= w_special_val;
                r_rd_addr <= md.rd_addr_i;
            end else if (w_store) begin
                r_rd_data <= w_result;
                r_rd_addr <= r_rd_addr_p;
            end
            r_cnt <= (r_state == MD_CALC && !md.flush_i && !w_last) ? r_cnt + 5'd1 : 5'd0;
        end
    end

    assign md.hold_flag_o    = w_hold;
    assign md.result_valid_o = w_valid;
    assign md.reg_wen_o      = w_valid;
    assign md.rd_data_o      = r_rd_data;
    assign md.rd_addr_o      = r_rd_addr;

    assign w_unused = ^{md.inst_i[24:15], md.inst_i[11:7], w_core_acc, w_core_opnd};

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
//==============================================================================
// Module      : tb_ex_muldiv
// Description : Directed bench with a result scoreboard for ex_muldiv.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if bus ();

    ex_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.inst_i    = c_INST_NOP;
        bus.op1_i     = '0;
        bus.op2_i     = '0;
        bus.rd_addr_i = '0;
        bus.reg_wen_i = 1'b0;
        bus.flush_i   = 1'b0;
    endtask

    function automatic logic [31:0] m_inst(input logic [2:0] f3, input logic [4:0] rd);
        return {c_FUNCT7_M, 5'd2, 5'd1, f3, rd, c_INST_TYPE_R_M};
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            c_F3_MUL:    begin p = sa * sb; return p[31:0]; end
            c_F3_MULH:   begin p = sa * sb; return p[63:32]; end
            c_F3_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            c_F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            c_F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            c_F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            c_F3_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default:     return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sp;
        sp = f3[2] && ((b == 0) ||
             (((f3 == c_F3_DIV) || (f3 == c_F3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
        return sp ? 1 : 33;
    endfunction

    // Issue one M op, wait (bounded) for its write-back strobe and score it.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_data, input int exp_lat);
        exp_t e, got;
        int   lat, hold_cnt;
        @(negedge clk);
        bus.inst_i    = m_inst(f3, rd);
        bus.op1_i     = a;
        bus.op2_i     = b;
        bus.rd_addr_i = rd;
        bus.reg_wen_i = 1'b1;
        e.data = exp_data; e.addr = rd; e.lat = exp_lat;
        sb.push_back(e);
        #1;
        hold_cnt = bus.hold_flag_o ? 1 : 0;
        @(negedge clk);
        drive_idle();
        #1;
        lat = 1;
        while (bus.reg_wen_o !== 1'b1 && lat < 100) begin
            if (bus.hold_flag_o) hold_cnt++;
            @(negedge clk);
            #1;
            lat++;
        end
        got = sb.pop_front();
        check("latency", 64'(lat), 64'(got.lat));
        check("hold_cycles", 64'(hold_cnt), 64'(got.lat));
        check("hold_in_done", bus.hold_flag_o, 1'b0);
        check("valid_eq_wen", bus.result_valid_o, 1'b1);
        check("rd_data", bus.rd_data_o, got.data);
        check("rd_addr", bus.rd_addr_o, got.addr);
        @(negedge clk);
        #1;
        check("wen_one_cycle", bus.reg_wen_o, 1'b0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int wen_seen, hold_seen;
        wen_seen = 0;
        hold_seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            #1;
            if (bus.reg_wen_o !== 1'b0) wen_seen++;
            if (bus.hold_flag_o !== 1'b0) hold_seen++;
        end
        check({tag, "_wen"}, 64'(wen_seen), 64'd0);
        check({tag, "_hold"}, 64'(hold_seen), 64'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;

        rst = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        check("rst_hold", bus.hold_flag_o, 1'b0);
        check("rst_valid", bus.result_valid_o, 1'b0);
        check("rst_wen", bus.reg_wen_o, 1'b0);
        check("rst_data", bus.rd_data_o, 32'h0);
        check("rst_addr", bus.rd_addr_o, 5'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(c_F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
        run_op(c_F3_DIVU,   32'd100,        32'd7,         5'd4,  32'h0000_000E, 33);
        run_op(c_F3_REMU,   32'd100,        32'd7,         5'd5,  32'h0000_0002, 33);
        run_op(c_F3_DIV,    32'hFFFF_FF9C,  32'd7,         5'd6,  32'hFFFF_FFF2, 33);
        run_op(c_F3_REM,    32'hFFFF_FF9C,  32'd7,         5'd7,  32'hFFFF_FFFE, 33);
        run_op(c_F3_DIV,    32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF, 1);
        run_op(c_F3_REMU,   32'd5,          32'd0,         5'd9,  32'h0000_0005, 1);
        run_op(c_F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        run_op(c_F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1);
        run_op(c_F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd12, 32'h4000_0000, 33);
        run_op(c_F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE, 33);
        run_op(c_F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFF, 33);

        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            run_op(f3, a, b, 5'(i + 16), ref_md(f3, a, b), ref_lat(f3, a, b));
        end

        // Reset in the middle of an iteration.
        @(negedge clk);
        bus.inst_i = m_inst(c_F3_MUL, 5'd20); bus.op1_i = 32'd3; bus.op2_i = 32'd9;
        bus.rd_addr_i = 5'd20; bus.reg_wen_i = 1'b1;
        @(negedge clk);
        drive_idle();
        repeat (10) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_hold", bus.hold_flag_o, 1'b0);
        check("mid_rst_wen", bus.reg_wen_o, 1'b0);
        check("mid_rst_valid", bus.result_valid_o, 1'b0);
        check("mid_rst_data", bus.rd_data_o, 32'h0);
        check("mid_rst_addr", bus.rd_addr_o, 5'd0);
        check("mid_rst_state", dut.r_state, MD_IDLE);
        @(negedge clk);
        rst = 1'b1;
        quiet("after_rst", 40);

        // Flush in the middle of an iteration.
        @(negedge clk);
        bus.inst_i = m_inst(c_F3_DIVU, 5'd21); bus.op1_i = 32'd1000; bus.op2_i = 32'd3;
        bus.rd_addr_i = 5'd21; bus.reg_wen_i = 1'b1;
        @(negedge clk);
        drive_idle();
        repeat (5) @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        check("flush_hold_same", bus.hold_flag_o, 1'b1);
        check("flush_wen_same", bus.reg_wen_o, 1'b0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        check("flush_hold_next", bus.hold_flag_o, 1'b0);
        quiet("after_flush", 40);

        // Flush while idle blocks acceptance.
        @(negedge clk);
        bus.inst_i = m_inst(c_F3_MUL, 5'd22); bus.op1_i = 32'd2; bus.op2_i = 32'd2;
        bus.rd_addr_i = 5'd22; bus.reg_wen_i = 1'b1; bus.flush_i = 1'b1;
        #1;
        check("idle_flush_hold", bus.hold_flag_o, 1'b0);
        @(negedge clk);
        drive_idle();
        quiet("idle_flush", 40);

        // M op without register write enable is not accepted.
        @(negedge clk);
        bus.inst_i = m_inst(c_F3_DIV, 5'd23); bus.op1_i = 32'd9; bus.op2_i = 32'd3;
        bus.rd_addr_i = 5'd23; bus.reg_wen_i = 1'b0;
        #1;
        check("no_wen_hold", bus.hold_flag_o, 1'b0);
        @(negedge clk);
        drive_idle();
        quiet("no_wen", 40);

        // Plain ADD is ignored.
        @(negedge clk);
        bus.inst_i = 32'h0020_81B3; bus.op1_i = 32'd1; bus.op2_i = 32'd2;
        bus.rd_addr_i = 5'd3; bus.reg_wen_i = 1'b1;
        #1;
        check("add_hold", bus.hold_flag_o, 1'b0);
        @(negedge clk);
        drive_idle();
        quiet("add", 40);

        run_op(c_F3_REMU, 32'd17, 32'd5, 5'd31, 32'h0000_0002, 33);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
